// File: rtl/mdu_ctrl.sv
// mdu_ctrl: owns HI/LO and sequences multi-cycle mult/div for the E stage.
// Optional MADD (E_Op=6) is built only when MDU_MADD_EN is defined.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        E_Start,
  input  logic [2:0]  E_Op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_UsesMDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic is_mul, is_div, is_madd, start_mc, issue, na, nb;
  logic [31:0] ua, ub, uq, ur, quo, rem;
  logic [63:0] prod_s, prod_u, madd_res, mc_res;
`ifdef MDU_MADD_EN
  assign is_madd  = E_Op == 3'd6;
  assign madd_res = {hi_q, lo_q} + prod_s;
`else
  assign is_madd  = 1'b0;
  assign madd_res = 64'd0;
`endif
  assign is_mul   = E_Op == 3'd0 || E_Op == 3'd1;
  assign is_div   = E_Op == 3'd2 || E_Op == 3'd3;
  assign start_mc = E_Start & (is_mul | is_div | is_madd);
  assign issue    = start_mc & (state_q == IDLE);
  assign Busy     = state_q == RUN;
  assign Stall    = (start_mc | Busy) & D_UsesMDU;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};
  // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
  assign na  = E_Op == 3'd2 && E_A[31];
  assign nb  = E_Op == 3'd2 && E_B[31];
  assign ua  = na ? -E_A : E_A;
  assign ub  = nb ? -E_B : E_B;
  assign uq  = ua / ub;
  assign ur  = ua % ub;
  assign quo = (na ^ nb) ? -uq : uq;
  assign rem = na ? -ur : ur;
  assign mc_res = is_madd ? madd_res :
                  E_Op == 3'd0 ? prod_s :
                  E_Op == 3'd1 ? prod_u :
                  ~|E_B ? {hi_q, lo_q} : {rem, quo};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (issue) begin
        state_d = RUN;
        cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        pend_d  = mc_res;
      end else if (E_Start && E_Op == 3'd4) hi_d = E_A;
      else if (E_Start && E_Op == 3'd5) lo_d = E_A;
    end else if (cnt_q == 4'd1) begin
      state_d      = IDLE;
      {hi_d, lo_d} = pend_q;
    end else cnt_d = cnt_q - 4'd1;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
